// File: rtl/program_loader.sv
// program_loader
//   Boot-time writer for the KGP-RISC instruction memory. Receives a byte
//   stream (2-byte word count N, 4*N payload bytes, 1 XOR checksum byte),
//   packs big-endian 32-bit words, and writes them to consecutive word
//   addresses starting at BASE_ADDR. The CPU is held in reset until a load
//   finishes with a matching checksum.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start         : begin a load (honoured in IDLE, DONE, ERR)
//   in_data/valid : byte stream source, in_ready is the accept side
//   imem_we/addr/wdata : single-cycle registered write to instruction memory
//   cpu_rst       : CPU reset hold, low only in DONE
//   busy/done/error : status (HDR/LOAD/CHK, DONE, ERR)
//   words_loaded  : words written in the current load (saturating)
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] LOAD_LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        restart;
  logic        hdr_seen;
  logic [7:0]  hdr_hi;
  logic [15:0] hdr_n;
  logic [15:0] n_words;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic [15:0] word_idx;
  logic [7:0]  xor_acc;
  logic        last_byte;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_ready  = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
  assign busy      = in_ready;
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign cpu_rst   = (state != S_DONE);
  assign accept    = in_valid && in_ready;
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign hdr_n     = {hdr_hi, in_data};
  assign last_byte = (byte_cnt == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (accept && hdr_seen) begin
          if (33'(hdr_n) > LOAD_LIMIT) state_nxt = S_ERR;
          else if (hdr_n == 16'd0)     state_nxt = S_CHK;
          else                         state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && last_byte && (word_idx == n_words - 16'd1)) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (accept) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hdr_seen     <= 1'b0;
      n_words      <= 16'd0;
      byte_cnt     <= 2'd0;
      word_idx     <= 16'd0;
      xor_acc      <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= ADDR_WIDTH'(BASE_ADDR);
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (restart) begin
        hdr_seen     <= 1'b0;
        byte_cnt     <= 2'd0;
        word_idx     <= 16'd0;
        xor_acc      <= 8'd0;
        words_loaded <= 16'd0;
      end
      // The checksum byte itself never enters the running XOR.
      if (accept && ((state == S_HDR) || (state == S_LOAD))) begin
        xor_acc <= xor_acc ^ in_data;
      end
      if (accept && (state == S_HDR)) begin
        hdr_seen <= 1'b1;
        if (hdr_seen) n_words <= hdr_n;
      end
      if (accept && (state == S_LOAD)) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          imem_we      <= 1'b1;
          imem_addr    <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
          imem_wdata   <= {asm_word, in_data};
          word_idx     <= word_idx + 16'd1;
          words_loaded <= sat_inc16(words_loaded);
        end
      end
    end
  end

  // Byte assembly datapath (no reset: contents only matter once filled)
  always_ff @(posedge clk) begin
    if (accept && (state == S_HDR) && !hdr_seen) hdr_hi <= in_data;
    if (accept && (state == S_LOAD) && !last_byte) asm_word <= {asm_word[15:0], in_data};
  end

endmodule
